sigdel_dac_ctrl: RTL

//  Sample-rate controller/scheduler in front of sigdel_dac. Buffers incoming PCM samples in a small FIFO.

---
 rtl/sigdel_pkg.sv | 17 +
 rtl/sigdel_sample_fifo.sv | 64 ++++++
 rtl/sigdel_dac_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sigdel_pkg.sv
// Shared types and helpers for the sigma-delta DAC sample-rate controller.
package sigdel_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD0 = 3'd1,
      LOAD1 = 3'd2,
      RUN   = 3'd3,
      HOLD  = 3'd4
   } sdc_state_t;

   // Offset-binary zero for a code of the given width (2**(bitlen-1)).
   function automatic logic [31:0] midscale(input int unsigned bitlen);
      midscale = 32'd1 << (bitlen - 32'd1);
   endfunction

endpackage

// File: rtl/sigdel_sample_fifo.sv
// Synchronous sample FIFO with registered occupancy count and a flush input.
// Read data is show-ahead: dout always presents the oldest entry.
module sigdel_sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == {CW{1'b0}});
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Storage write; a flushed or reset cycle stores nothing.
   always_ff @(posedge clk) begin
      if (w_push_ok && !flush && !rst) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking; push+pop in one cycle leaves count unchanged.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sigdel_dac_ctrl.sv
// Sample-rate controller in front of sigdel_dac: buffers PCM samples, releases
// one every 2**L clocks and linearly interpolates a per-clock code between them.
module sigdel_dac_ctrl
   import sigdel_pkg::*;
#(
   parameter int BITLEN       = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int OSR_LOG2_MAX = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [$clog2(OSR_LOG2_MAX+1)-1:0] osr_log2,
   input  logic [BITLEN-1:0]                 s_data,
   input  logic                              s_valid,
   output logic                              s_ready,
   output logic [BITLEN-1:0]                 dac_code,
   output logic                              dac_rst,
   output logic                              sample_tick,
   output logic                              underrun,
   output logic [15:0]                       underrun_cnt
);

   localparam int LW    = $clog2(OSR_LOG2_MAX + 1);
   localparam int PW    = (OSR_LOG2_MAX > 0) ? OSR_LOG2_MAX : 1;
   localparam int ACC_W = BITLEN + OSR_LOG2_MAX + 1;
   localparam int DW    = BITLEN + 1;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BITLEN-1:0] MIDSCALE = BITLEN'(midscale(BITLEN));

   sdc_state_t               r_state;
   sdc_state_t               w_state_nxt;

   logic [BITLEN-1:0]        r_cur;
   logic [BITLEN-1:0]        r_nxt;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [DW-1:0]     r_delta;
   logic [PW-1:0]            r_phase;
   logic [LW-1:0]            r_l;

   logic [BITLEN-1:0]        r_dac_code;
   logic                     r_dac_rst;
   logic                     r_tick;
   logic                     r_underrun;
   logic [15:0]              r_underrun_cnt;

   logic [LW-1:0]            w_l_clamped;
   logic                     w_flush;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic [CW-1:0]            w_count;
   logic [BITLEN-1:0]        w_fifo_dout;
   logic [PW:0]              w_span;
   logic                     w_boundary;
   logic [BITLEN-1:0]        w_interp;
   logic signed [ACC_W-1:0]  w_cur_sc;
   logic signed [ACC_W-1:0]  w_nxt_sc;
   logic [BITLEN-1:0]        w_delta_base;
   logic signed [DW-1:0]     w_delta_new;
   logic [BITLEN-1:0]        w_code_d;
   logic                     w_dac_rst_d;
   logic                     w_tick_d;
   logic                     w_underrun_d;

   // Out-of-range ratios saturate at the largest supported one.
   assign w_l_clamped = (osr_log2 > LW'(OSR_LOG2_MAX)) ? LW'(OSR_LOG2_MAX) : osr_log2;

   // Leaving a streaming state flushes the FIFO and discards that cycle's write.
   assign w_flush = !enable && (r_state != IDLE);
   assign s_ready = !rst && !w_full;
   assign w_push  = s_valid && s_ready && !w_flush;

   // Last phase index of a sample period is 2**L - 1.
   assign w_span     = ({{PW{1'b0}}, 1'b1} << r_l) - {{PW{1'b0}}, 1'b1};
   assign w_boundary = ({1'b0, r_phase} == w_span);

   // Floor of acc / 2**L; the accumulator never goes negative.
   assign w_interp = BITLEN'(r_acc >>> r_l);
   assign w_cur_sc = ACC_W'(r_cur) << r_l;
   assign w_nxt_sc = ACC_W'(r_nxt) << r_l;

   // New slope starts from cur when priming, otherwise from the sample being promoted.
   assign w_delta_base = (r_state == LOAD1) ? r_cur : r_nxt;
   assign w_delta_new  = $signed({1'b0, w_fifo_dout}) - $signed({1'b0, w_delta_base});

   sigdel_sample_fifo #(
      .WIDTH (BITLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_flush),
      .push  (w_push),
      .din   (s_data),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_count >= CW'(2)) begin
                  w_state_nxt = LOAD0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            LOAD0: w_state_nxt = LOAD1;
            LOAD1: w_state_nxt = RUN;
            RUN: begin
               if (w_boundary && w_empty) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_state_nxt = RUN;
               end
            end
            HOLD: begin
               if (!w_empty) begin
                  w_state_nxt = RUN;
               end else begin
                  w_state_nxt = HOLD;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // FSM output decode: FIFO pop and next values of the registered outputs.
   always_comb begin
      w_pop        = 1'b0;
      w_code_d     = MIDSCALE;
      w_dac_rst_d  = 1'b1;
      w_tick_d     = 1'b0;
      w_underrun_d = 1'b0;
      if (!enable) begin
         w_pop = 1'b0;
      end else begin
         case (r_state)
            IDLE:  w_pop = 1'b0;
            LOAD0: w_pop = 1'b1;
            LOAD1: w_pop = 1'b1;
            RUN: begin
               w_dac_rst_d = 1'b0;
               w_code_d    = w_interp;
               if (w_boundary) begin
                  w_tick_d     = 1'b1;
                  w_pop        = !w_empty;
                  w_underrun_d = w_empty;
               end else begin
                  w_tick_d = 1'b0;
               end
            end
            HOLD: begin
               w_dac_rst_d = 1'b0;
               w_code_d    = r_cur;
               w_pop       = !w_empty;
            end
            default: w_pop = 1'b0;
         endcase
      end
   end

   // Interpolator datapath: sample pair, accumulator, slope and phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur   <= {BITLEN{1'b0}};
         r_nxt   <= {BITLEN{1'b0}};
         r_acc   <= {ACC_W{1'b0}};
         r_delta <= {DW{1'b0}};
         r_phase <= {PW{1'b0}};
         r_l     <= {LW{1'b0}};
      end else if (enable) begin
         case (r_state)
            LOAD0: begin
               r_cur <= w_fifo_dout;
               r_l   <= w_l_clamped;
            end
            LOAD1: begin
               r_nxt   <= w_fifo_dout;
               r_acc   <= w_cur_sc;
               r_delta <= w_delta_new;
               r_phase <= {PW{1'b0}};
            end
            RUN: begin
               if (w_boundary) begin
                  r_cur   <= r_nxt;
                  r_acc   <= w_nxt_sc;
                  r_phase <= {PW{1'b0}};
                  if (!w_empty) begin
                     r_nxt   <= w_fifo_dout;
                     r_delta <= w_delta_new;
                  end
               end else begin
                  r_acc   <= r_acc + {{(ACC_W-DW){r_delta[DW-1]}}, r_delta};
                  r_phase <= r_phase + PW'(1);
               end
            end
            HOLD: begin
               if (!w_empty) begin
                  r_nxt   <= w_fifo_dout;
                  r_delta <= w_delta_new;
                  r_acc   <= w_cur_sc;
                  r_phase <= {PW{1'b0}};
               end
            end
            default: begin
               r_phase <= r_phase;
            end
         endcase
      end
   end

   // Registered outputs and the saturating underrun counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dac_code     <= MIDSCALE;
         r_dac_rst      <= 1'b1;
         r_tick         <= 1'b0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= 16'd0;
      end else begin
         r_dac_code <= w_code_d;
         r_dac_rst  <= w_dac_rst_d;
         r_tick     <= w_tick_d;
         r_underrun <= w_underrun_d;
         if (w_underrun_d && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
         end
      end
   end

   assign dac_code     = r_dac_code;
   assign dac_rst      = r_dac_rst;
   assign sample_tick  = r_tick;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;

endmodule
